// File: rtl/irq_source_decoder_6.sv
// irq_source_decoder_6
// Takes six raw interrupt sources and fixes their polarity. Each source passes
// through a two-flop synchroniser, and a third flop keeps the previous value for
// edge detection. The block presents the OR'ed request to the CPU. On an
// acknowledge it returns the highest-priority pending source as a vector, 1..6.
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_IDLE | no vector outstanding; an ack captures the current winner
// ST_GRANT| vector held on vec_out/vec_valid until ack_in drops
module irq_source_decoder_6 #(
  parameter logic [5:0] BUBBLES_MASK = 6'b000000,
  parameter logic [5:0] EDGE_MASK    = 6'b000000
) (
  input  logic       sysclk,
  input  logic       sys_rst_n,
  input  logic [5:0] req_in,
  input  logic [5:0] enable,
  input  logic       ack_in,
  output logic       req_out,
  output logic       vec_valid,
  output logic [2:0] vec_out,
  output logic [5:0] pending_out
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [5:0] sync1_q, sync1_d;
  logic [5:0] sync2_q, sync2_d;
  logic [5:0] sync3_q, sync3_d;
  logic [5:0] pending_q, pending_d;
  logic [5:0] hold_q, hold_d;
  logic [2:0] vec_q, vec_d;
  logic       vec_valid_q, vec_valid_d;
  logic       req_out_q, req_out_d;

  logic [5:0] real_req;
  logic [5:0] rise;
  logic [5:0] clr;
  logic [5:0] cand;
  logic [2:0] win_idx;
  logic       win_found;

  // Polarity correction before synchronisation; the sync chain shifts one stage per edge
  always_comb begin
    real_req = req_in ^ BUBBLES_MASK;
    sync1_d  = real_req;
    sync2_d  = sync1_q;
    sync3_d  = sync2_q;
    rise     = sync2_q & ~sync3_q;
  end

  // Fixed-priority pick among enabled pending sources; the highest index wins
  always_comb begin
    cand      = pending_q & enable;
    win_idx   = 3'd0;
    win_found = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (cand[i]) begin
        win_idx   = 3'(i);
        win_found = 1'b1;
      end
    end
  end

  // Next-state logic: the grant handshake, pending update and request aggregation
  always_comb begin
    state_d     = state_q;
    vec_d       = vec_q;
    vec_valid_d = vec_valid_q;
    hold_d      = hold_q;
    clr         = 6'b000000;

    case (state_q)
      ST_IDLE: begin
        if (ack_in) begin
          vec_d       = win_found ? (win_idx + 3'd1) : 3'd0;
          hold_d      = win_found ? (6'b000001 << win_idx) : 6'b000000;
          clr         = win_found ? (6'b000001 << win_idx) : 6'b000000;
          vec_valid_d = 1'b1;
          state_d     = ST_GRANT;
        end else begin
          vec_valid_d = 1'b0;
        end
      end
      ST_GRANT: begin
        if (!ack_in) begin
          vec_d       = 3'd0;
          vec_valid_d = 1'b0;
          hold_d      = 6'b000000;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Edge sources are sticky; a new edge beats a same-cycle grant clear.
    // Level sources simply track the synchronised input.
    pending_d = (EDGE_MASK & (rise | (pending_q & ~clr))) |
                (~EDGE_MASK & sync2_q);

    // The granted source is held off so a level source cannot re-request during its own ack
    req_out_d = |(pending_d & enable & ~hold_d);
  end

  // Register update with synchronous active-low reset
  always_ff @(posedge sysclk) begin
    if (!sys_rst_n) begin
      state_q     <= ST_IDLE;
      sync1_q     <= 6'b000000;
      sync2_q     <= 6'b000000;
      sync3_q     <= 6'b000000;
      pending_q   <= 6'b000000;
      hold_q      <= 6'b000000;
      vec_q       <= 3'd0;
      vec_valid_q <= 1'b0;
      req_out_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      sync3_q     <= sync3_d;
      pending_q   <= pending_d;
      hold_q      <= hold_d;
      vec_q       <= vec_d;
      vec_valid_q <= vec_valid_d;
      req_out_q   <= req_out_d;
    end
  end

  assign req_out     = req_out_q;
  assign vec_valid   = vec_valid_q;
  assign vec_out     = vec_q;
  assign pending_out = pending_q;

endmodule

// File: tb/tb_irq_source_decoder_6.sv
// Bench for irq_source_decoder_6: directed scenarios followed by a randomized run.
// Every output is compared each cycle against a reference model kept in the bench.
module tb_irq_source_decoder_6;

  localparam logic [5:0] BUB = 6'h20;
  localparam logic [5:0] EDG = 6'h05;

  logic       clk = 1'b0;
  logic       sys_rst_n;
  logic [5:0] req_in;
  logic [5:0] enable;
  logic       ack_in;
  logic       req_out;
  logic       vec_valid;
  logic [2:0] vec_out;
  logic [5:0] pending_out;

  int total = 0;
  int bad   = 0;

  // reference model state
  logic [5:0] h1, h2, h3;
  logic [5:0] m_pend;
  logic       m_req;
  logic       m_valid;
  logic [2:0] m_vec;
  logic       m_grant;
  int         m_hold;

  always #5 clk = ~clk;

  irq_source_decoder_6 #(
    .BUBBLES_MASK(BUB),
    .EDGE_MASK   (EDG)
  ) dut (
    .sysclk     (clk),
    .sys_rst_n  (sys_rst_n),
    .req_in     (req_in),
    .enable     (enable),
    .ack_in     (ack_in),
    .req_out    (req_out),
    .vec_valid  (vec_valid),
    .vec_out    (vec_out),
    .pending_out(pending_out)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock edge of the behavioural model, using the inputs sampled at that edge
  task automatic model_edge(input logic [5:0] r, input logic [5:0] e,
                            input logic a, input logic rn);
    int w;
    int clr_i;
    logic [5:0] np;
    if (!rn) begin
      h1 = '0; h2 = '0; h3 = '0;
      m_pend = '0; m_req = 1'b0; m_valid = 1'b0; m_vec = 3'd0;
      m_grant = 1'b0; m_hold = -1;
      return;
    end
    clr_i = -1;
    if (!m_grant && a) begin
      w = -1;
      for (int i = 5; i >= 0; i--)
        if (w < 0 && m_pend[i] && e[i]) w = i;
      m_vec   = (w < 0) ? 3'd0 : 3'(w + 1);
      m_valid = 1'b1;
      m_hold  = w;
      m_grant = 1'b1;
      if (w >= 0 && EDG[w]) clr_i = w;
    end else if (m_grant && !a) begin
      m_valid = 1'b0;
      m_vec   = 3'd0;
      m_hold  = -1;
      m_grant = 1'b0;
    end else if (!m_grant) begin
      m_valid = 1'b0;
    end
    for (int i = 0; i < 6; i++) begin
      if (EDG[i]) np[i] = (h2[i] && !h3[i]) || (m_pend[i] && i != clr_i);
      else        np[i] = h2[i];
    end
    m_pend = np;
    m_req  = 1'b0;
    for (int i = 0; i < 6; i++)
      if (np[i] && e[i] && i != m_hold) m_req = 1'b1;
    h3 = h2;
    h2 = h1;
    h1 = r ^ BUB;
  endtask

  task automatic step(input logic [5:0] r, input logic [5:0] e,
                      input logic a, input logic rn);
    req_in    = r;
    enable    = e;
    ack_in    = a;
    sys_rst_n = rn;
    @(posedge clk);
    model_edge(r, e, a, rn);
    #1;
    chk("req_out",     8'(req_out),     8'(m_req));
    chk("vec_valid",   8'(vec_valid),   8'(m_valid));
    chk("vec_out",     8'(vec_out),     8'(m_vec));
    chk("pending_out", 8'(pending_out), 8'(m_pend));
  endtask

  initial begin
    logic [5:0] r;
    logic [5:0] e;
    logic       a;
    logic       rn;

    sys_rst_n = 1'b0; req_in = 6'h3F; enable = 6'h3F; ack_in = 1'b0;
    m_hold = -1; m_grant = 1'b0;

    // reset with every raw input high
    step(6'h3F, 6'h3F, 1'b0, 1'b0);
    chk("rst_req_out", 8'(req_out), 8'h0);
    chk("rst_valid",   8'(vec_valid), 8'h0);
    chk("rst_pending", 8'(pending_out), 8'h0);

    // latency and priority with level sources 1 and 4 (bit 5 raw high = inactive)
    step(6'h32, 6'h3F, 1'b0, 1'b1);
    chk("lat_edge1", 8'(req_out), 8'h0);
    step(6'h32, 6'h3F, 1'b0, 1'b1);
    chk("lat_edge2", 8'(req_out), 8'h0);
    step(6'h32, 6'h3F, 1'b0, 1'b1);
    chk("lat_edge3", 8'(req_out), 8'h1);
    chk("lat_pending", 8'(pending_out), 8'h12);
    step(6'h32, 6'h3F, 1'b1, 1'b1);
    chk("prio_vec", 8'(vec_out), 8'h5);
    chk("prio_valid", 8'(vec_valid), 8'h1);
    step(6'h32, 6'h3F, 1'b0, 1'b1);
    chk("release_vec", 8'(vec_out), 8'h0);
    for (int i = 0; i < 3; i++) step(6'h20, 6'h3F, 1'b0, 1'b1);

    // sticky edge source 0: four-cycle pulse then low
    for (int i = 0; i < 4; i++) step(6'h21, 6'h3F, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step(6'h20, 6'h3F, 1'b0, 1'b1);
    chk("sticky_pending", 8'(pending_out), 8'h01);
    step(6'h20, 6'h3F, 1'b1, 1'b1);
    chk("sticky_vec", 8'(vec_out), 8'h1);
    chk("sticky_clear", 8'(pending_out), 8'h00);
    step(6'h20, 6'h3F, 1'b0, 1'b1);

    // inverted source 5 wins, then is masked off while staying pending
    for (int i = 0; i < 3; i++) step(6'h00, 6'h3F, 1'b0, 1'b1);
    step(6'h00, 6'h3F, 1'b1, 1'b1);
    chk("bubble_vec", 8'(vec_out), 8'h6);
    step(6'h00, 6'h3F, 1'b0, 1'b1);
    step(6'h00, 6'h1F, 1'b0, 1'b1);
    chk("mask_req_out", 8'(req_out), 8'h0);
    chk("mask_pending", 8'(pending_out), 8'h20);

    // spurious acknowledge
    for (int i = 0; i < 3; i++) step(6'h20, 6'h3F, 1'b0, 1'b1);
    step(6'h20, 6'h3F, 1'b1, 1'b1);
    chk("spur_vec", 8'(vec_out), 8'h0);
    chk("spur_valid", 8'(vec_valid), 8'h1);
    step(6'h20, 6'h3F, 1'b0, 1'b1);

    // edge source 2 re-edges on the very edge it is granted
    step(6'h24, 6'h3F, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step(6'h20, 6'h3F, 1'b0, 1'b1);
    step(6'h24, 6'h3F, 1'b0, 1'b1);
    step(6'h24, 6'h3F, 1'b0, 1'b1);
    step(6'h24, 6'h3F, 1'b1, 1'b1);
    chk("coll_vec", 8'(vec_out), 8'h3);
    chk("coll_pending", 8'(pending_out), 8'h04);

    // reset in the middle of a grant
    step(6'h24, 6'h3F, 1'b1, 1'b0);
    chk("rstg_valid", 8'(vec_valid), 8'h0);
    chk("rstg_vec", 8'(vec_out), 8'h0);
    chk("rstg_pending", 8'(pending_out), 8'h00);
    step(6'h24, 6'h3F, 1'b0, 1'b1);
    step(6'h24, 6'h3F, 1'b1, 1'b1);
    chk("rstg_idle_ack", 8'(vec_valid), 8'h1);
    chk("rstg_idle_vec", 8'(vec_out), 8'h0);

    // randomized run against the model
    step(6'h20, 6'h3F, 1'b0, 1'b0);
    r = 6'h20; a = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      r  = r ^ (6'($urandom) & 6'($urandom) & 6'($urandom));
      e  = 6'($urandom) | 6'($urandom);
      if ($urandom_range(3) == 0) a = ~a;
      rn = ($urandom_range(199) != 0);
      step(r, e, a, rn);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
